// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer so in_ready comes straight from a flop.
// Also handles synchronous flush on redirects and counts decode-stall cycles.
module if_id_skid_reg #(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_inst,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_inst,
    output logic             out_pred_taken,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    // state    | meaning
    // ST_EMPTY | no beat held
    // ST_HALF  | main entry holds the beat on the outputs
    // ST_FULL  | main plus one skidded beat behind it
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]      state;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] main_inst;
    logic            main_pred;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_inst;
    logic            skid_pred;
    logic            accept;
    logic            consume;

    assign in_ready       = (state != ST_FULL);
    assign out_valid      = (state != ST_EMPTY);
    assign accept         = in_valid & in_ready;
    assign consume        = out_valid & out_ready;
    assign out_pc         = out_valid ? main_pc   : '0;
    assign out_inst       = out_valid ? main_inst : NOP;
    assign out_pred_taken = out_valid & main_pred;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            main_pc   <= '0;
            main_inst <= '0;
            main_pred <= 1'b0;
            skid_pc   <= '0;
            skid_inst <= '0;
            skid_pred <= 1'b0;
            stall_cnt <= '0;
        end else begin
            // Stall accounting ignores flush: a redirect does not erase stalls already suffered.
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_ONE;

            if (flush) begin
                state <= ST_EMPTY;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_pc   <= in_pc;
                            main_inst <= in_inst;
                            main_pred <= in_pred_taken;
                            state     <= ST_HALF;
                        end
                    end
                    ST_HALF: begin
                        if (accept && consume) begin
                            main_pc   <= in_pc;
                            main_inst <= in_inst;
                            main_pred <= in_pred_taken;
                        end else if (accept) begin
                            skid_pc   <= in_pc;
                            skid_inst <= in_inst;
                            skid_pred <= in_pred_taken;
                            state     <= ST_FULL;
                        end else if (consume) begin
                            state <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (consume) begin
                            main_pc   <= skid_pc;
                            main_inst <= skid_inst;
                            main_pred <= skid_pred;
                            state     <= ST_HALF;
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios plus a randomized run
// compared against a queue-based model of the held beats.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_pred_taken;
    logic        out_ready;
    logic        flush;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [31:0] out_pc,    out_pc4;
    logic [31:0] out_inst,  out_inst4;
    logic        out_pred,  out_pred4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_pred_taken(out_pred),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    if_id_skid_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_inst(in_inst), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_pc(out_pc4), .out_inst(out_inst4), .out_pred_taken(out_pred4),
        .flush(flush), .stall_cnt(stall_cnt4)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pt;
    } beat_t;

    beat_t       q[$];
    int unsigned m_stall;
    int unsigned m_stall4;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    task automatic check_outputs();
        logic        e_v;
        logic [31:0] e_pc, e_inst;
        logic        e_pt;
        e_v    = (q.size() != 0);
        e_pc   = e_v ? q[0].pc   : 32'h0;
        e_inst = e_v ? q[0].inst : 32'h00000013;
        e_pt   = e_v ? q[0].pt   : 1'b0;
        check_val("out_valid", 32'(out_valid), 32'(e_v));
        check_val("in_ready",  32'(in_ready),  32'(q.size() < 2));
        check_val("out_pc",    out_pc,         e_pc);
        check_val("out_inst",  out_inst,       e_inst);
        check_val("out_pred",  32'(out_pred),  32'(e_pt));
        check_val("stall_cnt", 32'(stall_cnt), m_stall);
        check_val("out_valid4", 32'(out_valid4), 32'(e_v));
        check_val("in_ready4",  32'(in_ready4),  32'(q.size() < 2));
        check_val("out_pc4",    out_pc4,         e_pc);
        check_val("out_inst4",  out_inst4,       e_inst);
        check_val("out_pred4",  32'(out_pred4),  32'(e_pt));
        check_val("stall_cnt4", 32'(stall_cnt4), m_stall4);
    endtask

    // Model edge: the queue is the set of beats held, oldest first, at most two.
    task automatic model_edge();
        logic  acc, cons;
        beat_t b;
        acc  = in_valid && (q.size() < 2);
        cons = (q.size() != 0) && out_ready;
        if ((q.size() != 0) && !out_ready) begin
            if (m_stall  < 65535) m_stall++;
            if (m_stall4 < 15)    m_stall4++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
                b.pc = in_pc; b.inst = in_inst; b.pt = in_pred_taken;
                q.push_back(b);
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic pt, input logic ordy, input logic fl);
        in_valid = v; in_pc = pc; in_inst = inst; in_pred_taken = pt;
        out_ready = ordy; flush = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_pred_taken = 1'b0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        m_stall = 0;
        m_stall4 = 0;
        check_outputs();
        rst = 1'b1;
    endtask

    logic [31:0] next_pc;

    initial begin
        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_pred_taken = 1'b0;
        out_ready = 1'b0; flush = 1'b0;
        m_stall = 0; m_stall4 = 0;

        do_reset();
        check_val("rst_inst",  out_inst, 32'h00000013);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_stall", 32'(stall_cnt), 32'd0);

        // streaming at full rate
        cycle(1'b1, 32'h0, 32'hA0, 1'b0, 1'b1, 1'b0);
        check_val("stream0", out_pc, 32'h0);
        cycle(1'b1, 32'h4, 32'hA4, 1'b1, 1'b1, 1'b0);
        check_val("stream1", out_pc, 32'h4);
        cycle(1'b1, 32'h8, 32'hA8, 1'b0, 1'b1, 1'b0);
        check_val("stream2", out_pc, 32'h8);
        check_val("stream_ready", 32'(in_ready), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_val("stream_stall", 32'(stall_cnt), 32'd0);

        // back-pressure fills the skid entry, then drains in order
        cycle(1'b1, 32'h100, 32'hB0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, 32'hB4, 1'b1, 1'b0, 1'b0);
        check_val("bp_ready", 32'(in_ready), 32'd0);
        check_val("bp_hold",  out_pc, 32'h100);
        cycle(1'b1, 32'h108, 32'hB8, 1'b0, 1'b1, 1'b0);
        check_val("bp_drain1", out_pc, 32'h104);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_val("bp_drain2", 32'(out_valid), 32'd0);

        // flush while full with a beat on the input
        cycle(1'b1, 32'h300, 32'hC0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'hC4, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 32'hC8, 1'b1, 1'b0, 1'b1);
        check_val("fl_valid", 32'(out_valid), 32'd0);
        check_val("fl_inst",  out_inst, 32'h00000013);
        check_val("fl_ready", 32'(in_ready), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_val("fl_gone", 32'(out_valid), 32'd0);

        // asynchronous reset between edges while full
        cycle(1'b1, 32'h500, 32'hD0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h504, 32'hD4, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_val("ar_valid", 32'(out_valid), 32'd0);
        check_val("ar_stall", 32'(stall_cnt), 32'd0);
        check_val("ar_ready", 32'(in_ready),  32'd1);
        check_val("ar_inst",  out_inst, 32'h00000013);
        do_reset();

        // stall counter and saturation of the narrow instance
        cycle(1'b1, 32'h400, 32'hE0, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_val("stall5", 32'(stall_cnt), 32'd5);
        repeat (20) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_val("stall25", 32'(stall_cnt),  32'd25);
        check_val("stall_sat", 32'(stall_cnt4), 32'd15);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_val("stall_flush", 32'(stall_cnt), 32'd26);

        // randomized traffic
        do_reset();
        next_pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            cycle(v, next_pc, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
            if (v) next_pc = next_pc + 32'd4;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
